// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency, single-ported memory between
// the instruction-fetch (IF) port and the data-memory (DM) port.
// DM has priority; a streak counter stops DM from starving IF.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_done_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STK_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [STK_W-1:0]    streak_q,   streak_d;
    logic                owner_dm_q, owner_dm_d;
    logic                we_q,       we_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

    logic                grant_dm;
    logic                grant_if;

    // DM wins unless IF is waiting and has already been passed over STARVE_MAX times
    assign grant_dm = dm_req_i && !(if_req_i && (streak_q == STK_MAX));
    assign grant_if = if_req_i && !grant_dm;

    // State register and latched access; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Next-state: arbitrate in IDLE, count down the fixed latency in BUSY, pulse in DONE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!if_req_i) begin
                    streak_d = '0;
                end
                if (grant_dm) begin
                    state_d    = S_BUSY;
                    cnt_d      = CNT_LOAD;
                    owner_dm_d = 1'b1;
                    we_d       = dm_we_i;
                    addr_d     = dm_addr_i;
                    wdata_d    = dm_wdata_i;
                    // grant_dm with IF waiting implies streak < STARVE_MAX, so no overflow
                    if (if_req_i) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_if) begin
                    state_d    = S_BUSY;
                    cnt_d      = CNT_LOAD;
                    owner_dm_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = if_addr_i;
                    streak_d   = '0;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (owner_dm_q) begin
                            dm_rdata_d = mem_rdata_i;
                        end else begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en_o    = (state_q == S_BUSY);
    assign mem_we_o    = (state_q == S_BUSY) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign if_done_o   = (state_q == S_DONE) && !owner_dm_q;
    assign dm_done_o   = (state_q == S_DONE) &&  owner_dm_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    // Stall is the only combinational input-to-output path
    assign if_stall_o  = if_req_i && !if_done_o;
    assign dm_stall_o  = dm_req_i && !dm_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed accesses, scoreboard queues checked
// by a monitor on every done pulse.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_done, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_done, dm_stall;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:255];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_len = 0;
    int dm_done_count = 0;
    int wr3_cnt = 0;

    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] dm_exp_q[$];
    int            order_q[$];
    int            if_done_cyc_q[$];
    int            dm_done_cyc_q[$];

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_done_o  (if_done),
        .if_rdata_o (if_rdata),
        .if_stall_o (if_stall),
        .dm_req_i   (dm_req),
        .dm_we_i    (dm_we),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_done_o  (dm_done),
        .dm_rdata_o (dm_rdata),
        .dm_stall_o (dm_stall),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: preload, then commit writes on each BUSY write edge
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'hA000_0000;
        mem[8'h01] = 32'hA000_0001;
        mem[8'h02] = 32'hA000_0002;
        mem[8'h03] = 32'hA000_0003;
        mem[8'h07] = 32'h0022_1820;
        mem[8'h08] = 32'h8888_0008;
        mem[8'h12] = 32'h1234_5678;
        mem[8'h20] = 32'hC0DE_0020;
        mem[8'h21] = 32'hC0DE_0021;
        mem[8'h22] = 32'hC0DE_0022;
        mem[8'h23] = 32'hC0DE_0023;
        mem[8'h24] = 32'hC0DE_0024;
        mem[8'h30] = 32'h3030_3030;
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    // Monitor: pops the scoreboard on each done pulse, checks stall behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_len = 0;
        end else begin
            if (mem_en) busy_len++;
            if (mem_en && mem_we && mem_wdata == 32'h3 && mem_addr == 16'h0013) wr3_cnt++;
            if (if_req) chk("if_stall_level", if_stall, !if_done);
            if (dm_req) chk("dm_stall_level", dm_stall, !dm_done);
            if (if_done && dm_done) chk("both_done", 1, 0);
            if (if_done) begin
                $display("IF done cyc=%0d rdata=%h", cyc, if_rdata);
                chk("if_busy_len", busy_len, LAT);
                busy_len = 0;
                order_q.push_back(0);
                if_done_cyc_q.push_back(cyc);
                if (if_exp_q.size() == 0) chk("if_unexpected_done", 1, 0);
                else chk("if_rdata", if_rdata, if_exp_q.pop_front());
            end
            if (dm_done) begin
                $display("DM done cyc=%0d rdata=%h", cyc, dm_rdata);
                chk("dm_busy_len", busy_len, LAT);
                busy_len = 0;
                dm_done_count++;
                order_q.push_back(1);
                dm_done_cyc_q.push_back(cyc);
                if (dm_exp_q.size() == 0) chk("dm_unexpected_done", 1, 0);
                else chk("dm_rdata", dm_rdata, dm_exp_q.pop_front());
            end
        end
    end

    // Issue an IF read, hold it until done, advance at the end of DONE
    task automatic if_access(input logic [AW-1:0] a, input logic [DW-1:0] exp, input bit last);
        int n;
        if_exp_q.push_back(exp);
        if_req  = 1'b1;
        if_addr = a;
        #1 chk("if_stall_rise", if_stall, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_done && n < 60);
        if (!if_done) chk("if_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (last) if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [DW-1:0] exp, input bit last);
        int n;
        dm_exp_q.push_back(exp);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        #1 chk("dm_stall_rise", dm_stall, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_done && n < 60);
        if (!dm_done) chk("dm_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (last) begin
            dm_req = 1'b0;
            dm_we  = 1'b0;
        end
    endtask

    initial begin
        int start;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);

        // Reset in the middle of a DM write
        @(posedge clk); #1;
        dm_req = 1; dm_we = 1; dm_addr = 16'h0040; dm_wdata = 32'h55;
        @(posedge clk); #1;
        chk("abort_busy_en", mem_en, 1);
        chk("abort_busy_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_mem_we", mem_we, 0);
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_en", mem_en, 0);
        chk("post_rst_mem_addr", mem_addr, 0);
        chk("post_rst_mem_wdata", mem_wdata, 0);
        chk("post_rst_dm_done", dm_done, 0);
        chk("post_rst_dm_rdata", dm_rdata, 0);
        chk("abort_no_dm_done", dm_done_count, 0);

        // Single IF read, latency MEM_LAT+1 from the request cycle
        @(posedge clk); #1;
        start = cyc;
        if_access(16'h0007, 32'h0022_1820, 1);
        chk("if_latency", if_done_cyc_q[$] - start, LAT + 1);

        // Simultaneous IF and DM: DM first, IF done 4 cycles later
        order_q.delete();
        fork
            if_access(16'h0008, 32'h8888_0008, 1);
            dm_access(1'b0, 16'h0012, 32'h0, 32'h1234_5678, 1);
        join
        chk("sim_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            chk("sim_first_dm", order_q[0], 1);
            chk("sim_second_if", order_q[1], 0);
        end
        chk("sim_gap", if_done_cyc_q[$] - dm_done_cyc_q[$], 4);

        // DM write keeps dm_rdata; then read it back
        wr3_cnt = 0;
        dm_access(1'b1, 16'h0013, 32'h3, 32'h1234_5678, 1);
        chk("wr_cycles", wr3_cnt, LAT);
        dm_access(1'b0, 16'h0013, 32'h0, 32'h0000_0003, 1);

        // Starvation: 4 DM, 1 IF, DM resumes
        order_q.delete();
        fork
            begin
                dm_access(1'b0, 16'h0020, 32'h0, 32'hC0DE_0020, 0);
                dm_access(1'b0, 16'h0021, 32'h0, 32'hC0DE_0021, 0);
                dm_access(1'b0, 16'h0022, 32'h0, 32'hC0DE_0022, 0);
                dm_access(1'b0, 16'h0023, 32'h0, 32'hC0DE_0023, 0);
                dm_access(1'b0, 16'h0024, 32'h0, 32'hC0DE_0024, 1);
            end
            if_access(16'h0030, 32'h3030_3030, 1);
        join
        chk("starve_count", order_q.size(), 6);
        if (order_q.size() == 6) begin
            chk("starve_o0", order_q[0], 1);
            chk("starve_o1", order_q[1], 1);
            chk("starve_o2", order_q[2], 1);
            chk("starve_o3", order_q[3], 1);
            chk("starve_o4_if", order_q[4], 0);
            chk("starve_o5", order_q[5], 1);
        end

        // Back-to-back IF reads, period MEM_LAT+2
        if_done_cyc_q.delete();
        if_access(16'h0000, 32'hA000_0000, 0);
        if_access(16'h0001, 32'hA000_0001, 0);
        if_access(16'h0002, 32'hA000_0002, 0);
        if_access(16'h0003, 32'hA000_0003, 1);
        chk("b2b_count", if_done_cyc_q.size(), 4);
        if (if_done_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("b2b_spacing", if_done_cyc_q[i] - if_done_cyc_q[i-1], 4);
        end

        repeat (5) @(posedge clk);
        chk("if_queue_empty", if_exp_q.size(), 0);
        chk("dm_queue_empty", dm_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
